// File: rtl/shchk_scan_pkg.sv
// Shared types and default sizing for the delay-tap scan controller.
// Optional error statistics are enabled with SHCHK_SCAN_ERRSTAT_EN.
package shchk_scan_pkg;

  localparam int NTAPS_DEF   = 8;
  localparam int SAMPLES_DEF = 16;
  localparam int SETTLE_DEF  = 4;
  localparam int LAT_DEF     = 1;

  localparam int TAPW = $clog2(NTAPS_DEF);
  localparam int CNTW = $clog2(SAMPLES_DEF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_EVAL,
    S_DONE
  } scan_state_e;

endpackage

// File: rtl/shchk_scan_ctrl_win_find.sv
// Combinational passing-window finder: lowest/highest passing tap, any-pass
// flag, and whether every tap between them passed.
module shchk_win_find
  import shchk_scan_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  localparam int TW = $clog2(NTAPS)
) (
  input  logic [NTAPS-1:0] pass_map,
  output logic [TW-1:0]    lo,
  output logic [TW-1:0]    hi,
  output logic             valid,
  output logic             contig
);

  always_comb begin
    lo     = '0;
    hi     = '0;
    valid  = |pass_map;
    contig = |pass_map;
    // Descending scan leaves the lowest set bit in lo.
    for (int t = NTAPS - 1; t >= 0; t--) begin
      if (pass_map[t]) lo = TW'(t);
    end
    for (int t = 0; t < NTAPS; t++) begin
      if (pass_map[t]) hi = TW'(t);
    end
    for (int t = 0; t < NTAPS; t++) begin
      if (TW'(t) >= lo && TW'(t) <= hi && !pass_map[t]) contig = 1'b0;
    end
  end

endmodule

// File: rtl/shchk_scan_ctrl.sv
// Delay-tap sweep controller: per tap settle, launch a toggling pattern,
// compare the captured bit and record pass/fail. SHCHK_SCAN_ERRSTAT_EN adds
// worst-tap error statistics.
module shchk_scan_ctrl
  import shchk_scan_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int LAT     = LAT_DEF,
  localparam int TW = $clog2(NTAPS),
  localparam int CW = $clog2(SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             q_obs,
  output logic [TW-1:0]    tap_sel,
  output logic             d_launch,
  output logic             busy,
  output logic             done,
  output logic [NTAPS-1:0] pass_map,
  output logic             win_valid,
  output logic [TW-1:0]    win_lo,
  output logic [TW-1:0]    win_hi,
  output logic             win_contig,
`ifdef SHCHK_SCAN_ERRSTAT_EN
  output logic [CW-1:0]    err_max,
  output logic [TW-1:0]    err_max_tap,
  output logic             err_max_valid,
`endif
  output scan_state_e      state
);

  localparam logic [TW-1:0] TAP_LAST    = TW'(NTAPS - 1);
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]   RUN_LAST    = 16'(SAMPLES - 1);
  localparam logic [15:0]   DRAIN_LAST  = 16'(LAT - 1);

  scan_state_e      next_state;
  logic [15:0]      ph_cnt;
  logic             phase_end;
  logic [LAT-1:0]   pipe_val;
  logic [LAT-1:0]   pipe_vld;
  logic             cmp_en;
  logic             mismatch;
  logic [CW-1:0]    err_cnt;
  logic [TW-1:0]    wf_lo;
  logic [TW-1:0]    wf_hi;
  logic             wf_valid;
  logic             wf_contig;
  logic             start_ok;

  assign start_ok = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    phase_end = 1'b0;
    case (state)
      S_SETTLE: phase_end = (ph_cnt == SETTLE_LAST);
      S_RUN:    phase_end = (ph_cnt == RUN_LAST);
      S_DRAIN:  phase_end = (ph_cnt == DRAIN_LAST);
      default:  phase_end = 1'b0;
    endcase
  end

  // abort is only honoured in the busy states; start only in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_SETTLE;
      S_SETTLE: if (abort) next_state = S_IDLE; else if (phase_end) next_state = S_RUN;
      S_RUN:    if (abort) next_state = S_IDLE; else if (phase_end) next_state = S_DRAIN;
      S_DRAIN:  if (abort) next_state = S_IDLE; else if (phase_end) next_state = S_EVAL;
      S_EVAL:   if (abort) next_state = S_IDLE;
                else if (tap_sel == TAP_LAST) next_state = S_DONE;
                else next_state = S_SETTLE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SETTLE, S_RUN, S_DRAIN, S_EVAL: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || next_state != state) ph_cnt <= '0;
    else if (state != S_IDLE)       ph_cnt <= ph_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) d_launch <= 1'b0;
    else begin
      case (next_state)
        S_RUN:          d_launch <= (state == S_RUN) ? ~d_launch : 1'b1;
        S_DRAIN, S_EVAL: d_launch <= d_launch;
        default:        d_launch <= 1'b0;
      endcase
    end
  end

  // Expectation pipe: launched bit emerges LAT cycles later, aligned with q_obs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_val <= '0;
      pipe_vld <= '0;
    end else begin
      pipe_val[0] <= d_launch;
      pipe_vld[0] <= (state == S_RUN);
      for (int i = 1; i < LAT; i++) begin
        pipe_val[i] <= pipe_val[i-1];
        pipe_vld[i] <= pipe_vld[i-1];
      end
      if (state == S_SETTLE || start_ok) pipe_vld <= '0;
    end
  end

  assign cmp_en   = (state == S_RUN || state == S_DRAIN) && pipe_vld[LAT-1];
  assign mismatch = cmp_en && (q_obs != pipe_val[LAT-1]);

  always_ff @(posedge clk) begin
    if (rst || start_ok || state == S_EVAL) err_cnt <= '0;
    else if (mismatch && !(&err_cnt))       err_cnt <= err_cnt + 1'b1;
  end

  shchk_win_find #(.NTAPS(NTAPS)) u_win_find (
    .pass_map (pass_map),
    .lo       (wf_lo),
    .hi       (wf_hi),
    .valid    (wf_valid),
    .contig   (wf_contig)
  );

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      tap_sel    <= '0;
      pass_map   <= '0;
      win_valid  <= 1'b0;
      win_lo     <= '0;
      win_hi     <= '0;
      win_contig <= 1'b0;
    end else if (state == S_EVAL && !abort) begin
      pass_map[tap_sel] <= (err_cnt == '0);
      if (tap_sel != TAP_LAST) tap_sel <= tap_sel + 1'b1;
    end else if (state == S_DONE) begin
      win_valid  <= wf_valid;
      win_lo     <= wf_lo;
      win_hi     <= wf_hi;
      win_contig <= wf_contig;
    end
  end

`ifdef SHCHK_SCAN_ERRSTAT_EN
  // Strictly-greater update keeps the lowest tap on ties, as taps ascend.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_max       <= '0;
      err_max_tap   <= '0;
      err_max_valid <= 1'b0;
    end else if (state == S_EVAL && !abort) begin
      if (!err_max_valid || err_cnt > err_max) begin
        err_max     <= err_cnt;
        err_max_tap <= tap_sel;
      end
      err_max_valid <= 1'b1;
    end
  end
`endif

endmodule
